mem_port_arbiter: RTL and testbench

- Shares the single main-memory port between ICache line refills and DCache line refills/writebacks.
- Picks one requester and sequences a LINE_WORDS-word burst on the memory port.
- Streams read data back to, or write data from, the granted cache, and signals completion.
- Sits between the two caches and main memory; the caches keep ICacheMiss/DCacheMiss asserted to the hazard logic until they see their done pulse.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_burst_counter.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and requester IDs.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST_I = 2'd1,
        BURST_D = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_burst_counter.sv
// Issue/return beat counters for one cache-line burst on the memory port.
module mem_port_arbiter_burst_counter #(
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         inc_issue_i,
    input  logic                         inc_return_i,
    output logic [$clog2(LINE_WORDS):0]  issue_cnt_o,
    output logic                         issue_full_o,
    output logic                         last_beat_o
);
    localparam int unsigned CNT_W = $clog2(LINE_WORDS) + 1;

    logic [CNT_W-1:0] issue_cnt_q;
    logic [CNT_W-1:0] return_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_cnt_q  <= '0;
            return_cnt_q <= '0;
        end else if (clear_i) begin
            issue_cnt_q  <= '0;
            return_cnt_q <= '0;
        end else begin
            if (inc_issue_i) begin
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end
            if (inc_return_i) begin
                return_cnt_q <= return_cnt_q + CNT_W'(1);
            end
        end
    end

    assign issue_cnt_o  = issue_cnt_q;
    assign issue_full_o = (issue_cnt_q == CNT_W'(LINE_WORDS));
    // Final beat is the one being counted right now, so done fires in the same cycle.
    assign last_beat_o  = inc_return_i && (return_cnt_q == CNT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the main-memory port between ICache and DCache line bursts.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  CPU_CLK,
    input  logic                  CPU_RST_N,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [31:0]           i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_wready,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  d_done,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);
    localparam int unsigned OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int unsigned CNT_W = $clog2(LINE_WORDS) + 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

    arb_state_e            state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  winner;

    logic [CNT_W-1:0]      issue_cnt;
    logic                  issue_full, last_beat;
    logic                  burst, accept, inc_return;

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state_q <= IDLE;
            rr_q    <= REQ_D;
            we_q    <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            we_q    <= we_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        we_d     = we_q;
        base_d   = base_q;
        winner   = REQ_I;
        sel_addr = i_addr;
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    if (i_req && d_req) begin
                        winner = rr_q;
                        rr_d   = ~rr_q;
                    end else begin
                        winner = d_req ? REQ_D : REQ_I;
                    end
                    sel_addr = (winner == REQ_D) ? d_addr : i_addr;
                    state_d  = (winner == REQ_D) ? BURST_D : BURST_I;
                    we_d     = (winner == REQ_D) && d_we;
                    base_d   = sel_addr & LINE_MASK;
                end
            end
            BURST_I, BURST_D: begin
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_port_arbiter_burst_counter #(
        .LINE_WORDS (LINE_WORDS)
    ) u_burst_counter (
        .clk_i        (CPU_CLK),
        .rst_ni       (CPU_RST_N),
        .clear_i      (state_q == IDLE),
        .inc_issue_i  (accept),
        .inc_return_i (inc_return),
        .issue_cnt_o  (issue_cnt),
        .issue_full_o (issue_full),
        .last_beat_o  (last_beat)
    );

    assign burst     = (state_q == BURST_I) || (state_q == BURST_D);
    assign i_gnt     = (state_q == BURST_I);
    assign d_gnt     = (state_q == BURST_D);

    assign mem_en    = burst && !issue_full;
    assign accept    = mem_en && mem_ready;
    assign mem_we    = d_gnt && we_q;
    assign mem_addr  = mem_en ? (base_q + (ADDR_WIDTH'(issue_cnt) << 2)) : '0;
    assign mem_wdata = (mem_en && mem_we) ? d_wdata : '0;

    // Writes complete on command acceptance; reads complete on returned data.
    assign inc_return = mem_we ? accept : (burst && mem_rvalid);

    assign i_rvalid  = i_gnt && mem_rvalid;
    assign i_rdata   = i_rvalid ? mem_rdata : '0;
    assign d_rvalid  = d_gnt && !we_q && mem_rvalid;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign d_wready  = mem_we && accept;

    assign i_done    = i_gnt && last_beat;
    assign d_done    = d_gnt && last_beat;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with an in-order memory model and scoreboard queues.
module tb_mem_port_arbiter;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST_N = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        i_gnt, i_rvalid, i_done, d_wready, d_gnt, d_rvalid, d_done;
    logic        mem_en, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    mem_port_arbiter #(
        .LINE_WORDS (8),
        .ADDR_WIDTH (32)
    ) dut (
        .CPU_CLK    (CPU_CLK),
        .CPU_RST_N  (CPU_RST_N),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .i_done     (i_done),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wready   (d_wready),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    logic [136:0] all_out;
    assign all_out = {i_gnt, i_rvalid, i_rdata, i_done, d_wready, d_gnt, d_rvalid, d_rdata,
                      d_done, mem_en, mem_we, mem_addr, mem_wdata};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_idx = 0;

    typedef struct packed {
        int          t;
        logic [31:0] d;
    } ret_t;

    ret_t        ret_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_dat_q[$];

    int          s_cyc;
    logic        s_en, s_we, s_rdy, s_wready, s_igt, s_dgt, s_irv, s_drv, s_idone, s_ddone;
    logic [31:0] s_addr, s_wdata, s_ird, s_drd;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] wr_word(input int k);
        return 32'h5A00_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] pop_addr();
        if (exp_addr_q.size() == 0) return 32'hDEAD_BEEF;
        return exp_addr_q.pop_front();
    endfunction

    function automatic logic [31:0] pop_dat();
        if (exp_dat_q.size() == 0) return 32'hDEAD_BEEF;
        return exp_dat_q.pop_front();
    endfunction

    // Expected command addresses and data for one aligned 8-word line.
    task automatic push_line(input logic [31:0] base, input bit is_write);
        for (int k = 0; k < 8; k++) begin
            exp_addr_q.push_back(base + 32'(4 * k));
            exp_dat_q.push_back(is_write ? wr_word(k) : rd_word(base + 32'(4 * k)));
        end
    endtask

    // Sample outputs at the falling edge, then model memory returns and DCache word advance.
    task automatic step();
        @(negedge CPU_CLK);
        s_cyc = cyc;       s_en = mem_en;     s_we = mem_we;     s_rdy = mem_ready;
        s_addr = mem_addr; s_wdata = mem_wdata; s_wready = d_wready;
        s_igt = i_gnt;     s_dgt = d_gnt;     s_irv = i_rvalid;  s_drv = d_rvalid;
        s_ird = i_rdata;   s_drd = d_rdata;   s_idone = i_done;  s_ddone = d_done;
        if (s_en && s_rdy && !s_we) ret_q.push_back('{t: cyc + 2, d: rd_word(s_addr)});
        @(posedge CPU_CLK);
        #1;
        cyc++;
        if (s_wready) begin
            wr_idx++;
            d_wdata = wr_word(wr_idx);
        end
        if (ret_q.size() > 0 && ret_q[0].t == cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = ret_q[0].d;
            void'(ret_q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
    endtask

    task automatic test_reset();
        CPU_RST_N = 1'b0;
        mem_ready = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", all_out);
        end
        step();
        step();
        CPU_RST_N = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL idle_rvalid_ignored got=%h exp=0", all_out);
        end
        mem_rvalid = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic test_single_iread();
        int beats = 0;
        int first_gnt = -1;
        int t0;
        bit done = 0;
        logic [31:0] e;
        push_line(32'h0000_1040, 1'b0);
        mem_ready = 1'b1;
        i_addr = 32'h0000_104C;
        i_req = 1'b1;
        t0 = cyc;
        for (int n = 0; n < 60 && !done; n++) begin
            step();
            if (first_gnt < 0 && s_igt) first_gnt = s_cyc - t0;
            checks++;
            if (s_dgt !== 1'b0) begin
                failures++; $display("FAIL iread_dgt got=%b exp=0", s_dgt);
            end
            if (s_en && s_rdy) begin
                checks++; e = pop_addr();
                if (s_addr !== e) begin
                    failures++; $display("FAIL iread_addr got=%h exp=%h", s_addr, e);
                end
            end
            if (s_irv) begin
                beats++; checks++; e = pop_dat();
                if (s_ird !== e) begin
                    failures++; $display("FAIL iread_data got=%h exp=%h", s_ird, e);
                end
            end
            if (s_idone) begin
                done = 1; checks++;
                if (beats != 8) begin
                    failures++; $display("FAIL iread_done_beat got=%0d exp=8", beats);
                end
            end
        end
        i_req = 1'b0;
        checks++;
        if (!done) begin failures++; $display("FAIL iread_timeout got=no_done exp=done"); end
        checks++;
        if (first_gnt != 1) begin
            failures++; $display("FAIL iread_gnt_latency got=%0d exp=1", first_gnt);
        end
        step();
        checks++;
        if (s_igt !== 1'b0) begin failures++; $display("FAIL iread_bubble got=%b exp=0", s_igt); end
        checks++;
        if (exp_addr_q.size() != 0) begin
            failures++; $display("FAIL iread_cmds_left got=%0d exp=0", exp_addr_q.size());
        end
    endtask

    task automatic test_rr_arbitration();
        logic [31:0] e;
        for (int r = 0; r < 2; r++) begin
            int nd = 0;
            bit side[2];
            bit exp_first;
            step();
            exp_first = (r == 0);
            if (r == 0) begin
                push_line(32'h0000_3000, 1'b0); push_line(32'h0000_4000, 1'b0);
            end else begin
                push_line(32'h0000_4100, 1'b0); push_line(32'h0000_3100, 1'b0);
            end
            d_addr = (r == 0) ? 32'h0000_3000 : 32'h0000_3100;
            i_addr = (r == 0) ? 32'h0000_4000 : 32'h0000_4100;
            d_we = 1'b0; i_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
            for (int n = 0; n < 120 && nd < 2; n++) begin
                step();
                checks++;
                if (s_igt && s_dgt) begin
                    failures++; $display("FAIL rr_gnt_exclusive got=11 exp=not_both");
                end
                if (s_en && s_rdy) begin
                    checks++; e = pop_addr();
                    if (s_addr !== e) begin
                        failures++; $display("FAIL rr_addr got=%h exp=%h", s_addr, e);
                    end
                end
                if (s_irv || s_drv) begin
                    checks++; e = pop_dat();
                    if ((s_irv ? s_ird : s_drd) !== e) begin
                        failures++;
                        $display("FAIL rr_data got=%h exp=%h", s_irv ? s_ird : s_drd, e);
                    end
                end
                if (s_ddone) begin side[nd] = 1'b1; nd++; d_req = 1'b0; end
                if (s_idone) begin side[nd] = 1'b0; nd++; i_req = 1'b0; end
            end
            checks++;
            if (nd != 2) begin
                failures++; $display("FAIL rr_timeout round=%0d got=%0d exp=2", r, nd);
            end else begin
                checks++;
                if (side[0] !== exp_first || side[1] !== !exp_first) begin
                    failures++;
                    $display("FAIL rr_order round=%0d got=%b%b exp=%b%b", r, side[0], side[1],
                             exp_first, !exp_first);
                end
            end
        end
    endtask

    task automatic test_writeback();
        int acc = 0;
        bit done = 0;
        logic [31:0] e;
        push_line(32'h0000_2000, 1'b1);
        wr_idx = 0;
        d_wdata = wr_word(0);
        d_addr = 32'h0000_2000; d_we = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
        for (int n = 0; n < 60 && !done; n++) begin
            step();
            mem_ready = ~mem_ready;
            checks++;
            if (s_wready !== (s_en && s_rdy)) begin
                failures++; $display("FAIL wb_wready got=%b exp=%b", s_wready, s_en && s_rdy);
            end
            checks++;
            if (s_drv !== 1'b0) begin failures++; $display("FAIL wb_rvalid got=%b exp=0", s_drv); end
            if (s_en) begin
                checks++;
                if (s_we !== 1'b1) begin failures++; $display("FAIL wb_we got=%b exp=1", s_we); end
            end
            if (s_en && s_rdy) begin
                acc++;
                checks++; e = pop_addr();
                if (s_addr !== e) begin
                    failures++; $display("FAIL wb_addr got=%h exp=%h", s_addr, e);
                end
                checks++; e = pop_dat();
                if (s_wdata !== e) begin
                    failures++; $display("FAIL wb_data got=%h exp=%h", s_wdata, e);
                end
            end
            if (s_ddone) begin
                done = 1; checks++;
                if (acc != 8 || s_wready !== 1'b1) begin
                    failures++; $display("FAIL wb_done got=%0d/%b exp=8/1", acc, s_wready);
                end
            end
        end
        d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b1;
        checks++;
        if (!done) begin failures++; $display("FAIL wb_timeout got=no_done exp=done"); end
        step();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int stall = 0;
        int beats = 0;
        bit done = 0;
        logic [31:0] e;
        push_line(32'h0000_5000, 1'b0);
        i_addr = 32'h0000_5000; i_req = 1'b1; mem_ready = 1'b1;
        for (int n = 0; n < 80 && !done; n++) begin
            step();
            if (!s_rdy) begin
                checks++;
                if (s_en !== 1'b1 || s_addr !== 32'h0000_500C) begin
                    failures++;
                    $display("FAIL bp_hold got=%b/%h exp=1/0000500c", s_en, s_addr);
                end
            end
            if (s_en && s_rdy) begin
                acc++; checks++; e = pop_addr();
                if (s_addr !== e) begin
                    failures++; $display("FAIL bp_addr got=%h exp=%h", s_addr, e);
                end
            end
            if (s_irv) begin
                beats++; checks++; e = pop_dat();
                if (s_ird !== e) begin
                    failures++; $display("FAIL bp_data got=%h exp=%h", s_ird, e);
                end
            end
            if (s_idone) done = 1;
            if (acc == 3 && stall < 5) begin
                mem_ready = 1'b0; stall++;
            end else begin
                mem_ready = 1'b1;
            end
        end
        i_req = 1'b0;
        checks++;
        if (!done || beats != 8 || acc != 8) begin
            failures++; $display("FAIL bp_complete got=%0d/%0d exp=8/8", acc, beats);
        end
        step();
    endtask

    task automatic test_reset_midburst();
        int beats = 0;
        int late = 0;
        bit done = 0;
        logic [31:0] e;
        push_line(32'h0000_6000, 1'b0);
        i_addr = 32'h0000_6000; i_req = 1'b1; mem_ready = 1'b1;
        for (int n = 0; n < 40 && beats < 3; n++) begin
            step();
            if (s_irv) beats++;
        end
        CPU_RST_N = 1'b0;
        i_req = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL rst_mid_outputs got=%h exp=0", all_out);
        end
        for (int n = 0; n < 6; n++) begin
            step();
            CPU_RST_N = 1'b1;
            if (s_irv || s_drv || s_en || s_igt) late++;
        end
        checks++;
        if (late != 0) begin failures++; $display("FAIL rst_mid_late got=%0d exp=0", late); end
        exp_addr_q.delete();
        exp_dat_q.delete();
        push_line(32'h0000_7000, 1'b0);
        beats = 0;
        i_addr = 32'h0000_7010; i_req = 1'b1;
        for (int n = 0; n < 60 && !done; n++) begin
            step();
            if (s_en && s_rdy) begin
                checks++; e = pop_addr();
                if (s_addr !== e) begin
                    failures++; $display("FAIL rst_new_addr got=%h exp=%h", s_addr, e);
                end
            end
            if (s_irv) begin
                beats++; checks++; e = pop_dat();
                if (s_ird !== e) begin
                    failures++; $display("FAIL rst_new_data got=%h exp=%h", s_ird, e);
                end
            end
            if (s_idone) done = 1;
        end
        i_req = 1'b0;
        checks++;
        if (!done || beats != 8) begin
            failures++; $display("FAIL rst_new_burst got=%0d exp=8", beats);
        end
        step();
    endtask

    task automatic test_req_drop();
        int beats = 0;
        int stray = 0;
        bit done = 0;
        logic [31:0] e;
        push_line(32'h0000_8000, 1'b0);
        d_addr = 32'h0000_8000; d_we = 1'b0; d_req = 1'b1; mem_ready = 1'b1;
        for (int n = 0; n < 60 && !done; n++) begin
            step();
            if (s_en && s_rdy) begin
                checks++; e = pop_addr();
                if (s_addr !== e) begin
                    failures++; $display("FAIL drop_addr got=%h exp=%h", s_addr, e);
                end
            end
            if (s_drv) begin
                beats++; checks++; e = pop_dat();
                if (s_drd !== e) begin
                    failures++; $display("FAIL drop_data got=%h exp=%h", s_drd, e);
                end
                if (beats == 2) d_req = 1'b0;
            end
            if (s_ddone) done = 1;
        end
        checks++;
        if (!done || beats != 8) begin
            failures++; $display("FAIL drop_done got=%0d exp=8", beats);
        end
        for (int n = 0; n < 3; n++) begin
            step();
            if (s_dgt || s_igt || s_en) stray++;
        end
        checks++;
        if (stray != 0) begin failures++; $display("FAIL drop_idle got=%0d exp=0", stray); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_iread();
        test_rr_arbitration();
        test_writeback();
        test_backpressure();
        test_reset_midburst();
        test_req_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
